spm_bus_arbiter: RTL and testbench

//   Shares the single-port scratchpad memory (SPM) between three requesters: the external test/loader

---
 rtl/spm_bus_arbiter_pkg.sv | 28 ++
 rtl/spm_bus_arbiter_rd_return.sv | 73 +++++++
 rtl/spm_bus_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_spm_bus_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spm_bus_arbiter_pkg
// Purpose  : Shared constants and types for the SPM bus arbiter: the SPM
//            access direction encoding, arbiter FSM states and read-return
//            owner identifiers.
// Revision : 1.0 - initial release
// ============================================================================
package spm_bus_arbiter_pkg;

    localparam logic SPM_READ  = 1'b1;
    localparam logic SPM_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_RUN    = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_TEST = 2'd1,
        OWNER_IF   = 2'd2,
        OWNER_MEM  = 2'd3
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/spm_bus_arbiter_rd_return.sv
`default_nettype none
// ============================================================================
// Module   : spm_rd_return
// Purpose  : Remembers which requester owns the SPM read issued this cycle and
//            steers the synchronous SPM read data to that requester on the
//            following cycle. Non-owners see zero data.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            grant_vld/owner/rw  - access granted this cycle and its owner
//            spm_rd_data         - read data from the SPM (one cycle latency)
//            <req>_rd_data/valid - per-requester read return
// Revision : 1.0 - initial release
// ============================================================================
module spm_rd_return
    import spm_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grant_vld,
    input  owner_t            grant_owner,
    input  logic              grant_rw,
    input  logic [DATA_W-1:0] spm_rd_data,
    output logic [DATA_W-1:0] test_rd_data,
    output logic              test_rd_valid,
    output logic [DATA_W-1:0] if_rd_data,
    output logic              if_rd_valid,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_valid
);

    owner_t r_owner;

    // Writes produce no return, so they record OWNER_NONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWNER_NONE;
        end else if (grant_vld && (grant_rw == SPM_READ)) begin
            r_owner <= grant_owner;
        end else begin
            r_owner <= OWNER_NONE;
        end
    end

    // A return still pending while reset is held is dropped.
    always_comb begin
        test_rd_data  = '0;
        test_rd_valid = 1'b0;
        if_rd_data    = '0;
        if_rd_valid   = 1'b0;
        mem_rd_data   = '0;
        mem_rd_valid  = 1'b0;
        if (!reset) begin
            case (r_owner)
                OWNER_TEST: begin
                    test_rd_data  = spm_rd_data;
                    test_rd_valid = 1'b1;
                end
                OWNER_IF: begin
                    if_rd_data  = spm_rd_data;
                    if_rd_valid = 1'b1;
                end
                OWNER_MEM: begin
                    mem_rd_data  = spm_rd_data;
                    mem_rd_valid = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spm_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spm_bus_arbiter
// Purpose  : Shares a single-port scratchpad memory between the test/loader
//            port, the CPU fetch stage (IF) and the CPU data stage (MEM).
//            One access is granted per cycle; losers are stalled. Ownership
//            moves between loader and CPU through a one-cycle SWITCH state.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            cpu_en                 - 1: CPU owns SPM, 0: loader owns SPM
//            test_spm_*             - loader request / read return / error
//            if_spm_*, if_stall     - fetch request / return / stall
//            mem_spm_*, mem_stall   - load/store request / return / stall
//            spm_*                  - SPM interface
// Config   : SPM_ARB_RR_EN - when defined, IF/MEM contention in RUN
//            alternates; otherwise MEM always beats IF.
// Revision : 1.0 - initial release
// ============================================================================
module spm_bus_arbiter
    import spm_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_en,
    input  logic [ADDR_W-1:0] test_spm_addr,
    input  logic              test_spm_as_,
    input  logic              test_spm_rw,
    input  logic [DATA_W-1:0] test_spm_wr_data,
    output logic [DATA_W-1:0] test_spm_rd_data,
    output logic              test_spm_rd_valid,
    output logic              test_spm_err,
    input  logic [ADDR_W-1:0] if_spm_addr,
    input  logic              if_spm_as_,
    output logic [DATA_W-1:0] if_spm_rd_data,
    output logic              if_spm_rd_valid,
    output logic              if_stall,
    input  logic [ADDR_W-1:0] mem_spm_addr,
    input  logic              mem_spm_as_,
    input  logic              mem_spm_rw,
    input  logic [DATA_W-1:0] mem_spm_wr_data,
    output logic [DATA_W-1:0] mem_spm_rd_data,
    output logic              mem_spm_rd_valid,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    owner_t     w_owner;
    logic       w_test_req;
    logic       w_if_req;
    logic       w_mem_req;
    logic       w_contend;
    logic       w_gnt_test;
    logic       w_gnt_if;
    logic       w_gnt_mem;
    logic       w_gnt_vld;

    assign w_test_req = !test_spm_as_;
    assign w_if_req   = !if_spm_as_;
    assign w_mem_req  = !mem_spm_as_;
    assign w_contend  = w_if_req && w_mem_req;

`ifdef SPM_ARB_RR_EN
    // Requester favoured at the next IF/MEM contention; flips each time a
    // contended grant is made so the two take turns.
    owner_t r_prio;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio <= OWNER_MEM;
        end else if ((r_state == ST_RUN) && w_contend) begin
            r_prio <= (r_prio == OWNER_MEM) ? OWNER_IF : OWNER_MEM;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_test  = 1'b0;
        w_gnt_if    = 1'b0;
        w_gnt_mem   = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_gnt_test = w_test_req;
                if (cpu_en) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_state_nxt = cpu_en ? ST_RUN : ST_LOAD;
            end
            ST_RUN: begin
                if (w_contend) begin
`ifdef SPM_ARB_RR_EN
                    w_gnt_mem = (r_prio == OWNER_MEM);
                    w_gnt_if  = (r_prio != OWNER_MEM);
`else
                    w_gnt_mem = 1'b1;
`endif
                end else begin
                    w_gnt_mem = w_mem_req;
                    w_gnt_if  = w_if_req;
                end
                if (!cpu_en) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
            end
        endcase
        // The state register is not yet meaningful while reset is held.
        if (reset) begin
            w_gnt_test = 1'b0;
            w_gnt_if   = 1'b0;
            w_gnt_mem  = 1'b0;
        end
    end

    assign w_gnt_vld    = w_gnt_test || w_gnt_if || w_gnt_mem;
    assign if_stall     = w_if_req && !w_gnt_if;
    assign mem_stall    = w_mem_req && !w_gnt_mem;
    assign test_spm_err = w_test_req && (r_state != ST_LOAD) && !reset;

    always_comb begin
        spm_as_     = 1'b1;
        spm_rw      = SPM_READ;
        spm_addr    = '0;
        spm_wr_data = '0;
        w_owner     = OWNER_NONE;
        if (w_gnt_test) begin
            spm_as_     = 1'b0;
            spm_rw      = test_spm_rw;
            spm_addr    = test_spm_addr;
            spm_wr_data = test_spm_wr_data;
            w_owner     = OWNER_TEST;
        end else if (w_gnt_mem) begin
            spm_as_     = 1'b0;
            spm_rw      = mem_spm_rw;
            spm_addr    = mem_spm_addr;
            spm_wr_data = mem_spm_wr_data;
            w_owner     = OWNER_MEM;
        end else if (w_gnt_if) begin
            spm_as_     = 1'b0;
            spm_addr    = if_spm_addr;
            w_owner     = OWNER_IF;
        end
    end

    spm_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk           (clk),
        .reset         (reset),
        .grant_vld     (w_gnt_vld),
        .grant_owner   (w_owner),
        .grant_rw      (spm_rw),
        .spm_rd_data   (spm_rd_data),
        .test_rd_data  (test_spm_rd_data),
        .test_rd_valid (test_spm_rd_valid),
        .if_rd_data    (if_spm_rd_data),
        .if_rd_valid   (if_spm_rd_valid),
        .mem_rd_data   (mem_spm_rd_data),
        .mem_rd_valid  (mem_spm_rd_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_spm_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spm_bus_arbiter
// Purpose  : Self-checking bench for spm_bus_arbiter with a behavioural SPM
//            and a scoreboard of expected read returns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spm_bus_arbiter;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_en;
    logic [ADDR_W-1:0] test_spm_addr;
    logic              test_spm_as_;
    logic              test_spm_rw;
    logic [DATA_W-1:0] test_spm_wr_data;
    logic [DATA_W-1:0] test_spm_rd_data;
    logic              test_spm_rd_valid;
    logic              test_spm_err;
    logic [ADDR_W-1:0] if_spm_addr;
    logic              if_spm_as_;
    logic [DATA_W-1:0] if_spm_rd_data;
    logic              if_spm_rd_valid;
    logic              if_stall;
    logic [ADDR_W-1:0] mem_spm_addr;
    logic              mem_spm_as_;
    logic              mem_spm_rw;
    logic [DATA_W-1:0] mem_spm_wr_data;
    logic [DATA_W-1:0] mem_spm_rd_data;
    logic              mem_spm_rd_valid;
    logic              mem_stall;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_;
    logic              spm_rw;
    logic [DATA_W-1:0] spm_wr_data;
    logic [DATA_W-1:0] spm_rd_data;

    spm_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_en            (cpu_en),
        .test_spm_addr     (test_spm_addr),
        .test_spm_as_      (test_spm_as_),
        .test_spm_rw       (test_spm_rw),
        .test_spm_wr_data  (test_spm_wr_data),
        .test_spm_rd_data  (test_spm_rd_data),
        .test_spm_rd_valid (test_spm_rd_valid),
        .test_spm_err      (test_spm_err),
        .if_spm_addr       (if_spm_addr),
        .if_spm_as_        (if_spm_as_),
        .if_spm_rd_data    (if_spm_rd_data),
        .if_spm_rd_valid   (if_spm_rd_valid),
        .if_stall          (if_stall),
        .mem_spm_addr      (mem_spm_addr),
        .mem_spm_as_       (mem_spm_as_),
        .mem_spm_rw        (mem_spm_rw),
        .mem_spm_wr_data   (mem_spm_wr_data),
        .mem_spm_rd_data   (mem_spm_rd_data),
        .mem_spm_rd_valid  (mem_spm_rd_valid),
        .mem_stall         (mem_stall),
        .spm_addr          (spm_addr),
        .spm_as_           (spm_as_),
        .spm_rw            (spm_rw),
        .spm_wr_data       (spm_wr_data),
        .spm_rd_data       (spm_rd_data)
    );

    always #5 clk = ~clk;

    // Owner codes used by the scoreboard.
    localparam logic [1:0] O_TEST = 2'd1;
    localparam logic [1:0] O_IF   = 2'd2;
    localparam logic [1:0] O_MEM  = 2'd3;

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc_cnt  = 0;
    logic [31:0] spm_mem [0:255];
    logic [31:0] shadow  [0:255];
    logic        rr_mem_next = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural single-port SPM with one-cycle synchronous read.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (!spm_as_) begin
            if (spm_rw == 1'b0) spm_mem[spm_addr[7:0]] <= spm_wr_data;
            spm_rd_data <= spm_mem[spm_addr[7:0]];
        end
    end

    // Read-return monitor: compares every returned read against the queue.
    always @(negedge clk) begin
        logic [1:0]  got_o;
        logic [31:0] got_d;
        logic [31:0] other_d;
        int          n_vld;
        exp_t        e;
        n_vld = int'(test_spm_rd_valid) + int'(if_spm_rd_valid) + int'(mem_spm_rd_valid);
        got_o = 2'd0; got_d = '0; other_d = '0;
        if (test_spm_rd_valid) begin
            got_o = O_TEST; got_d = test_spm_rd_data; other_d = if_spm_rd_data | mem_spm_rd_data;
        end else if (if_spm_rd_valid) begin
            got_o = O_IF; got_d = if_spm_rd_data; other_d = test_spm_rd_data | mem_spm_rd_data;
        end else if (mem_spm_rd_valid) begin
            got_o = O_MEM; got_d = mem_spm_rd_data; other_d = test_spm_rd_data | if_spm_rd_data;
        end
        if (n_vld != 0) begin
            chk("rd_onehot", n_vld, 1);
            chk("rd_other_zero", other_d, 0);
            if (sb_q.size() == 0) begin
                chk("rd_unexpected", got_o, 0);
            end else begin
                e = sb_q.pop_front();
                chk("rd_cycle", cyc_cnt, e.cyc);
                chk("rd_owner", got_o, e.owner);
                chk("rd_data", got_d, e.data);
            end
        end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc_cnt) begin
            e = sb_q.pop_front();
            chk("rd_missing", 0, 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        test_spm_as_ = 1'b1;
        if_spm_as_   = 1'b1;
        mem_spm_as_  = 1'b1;
    endtask

    task automatic push(input logic [1:0] o, input logic [31:0] d);
        exp_t e;
        e.owner = o; e.data = d; e.cyc = cyc_cnt + 1;
        sb_q.push_back(e);
    endtask

    // One RUN cycle with IF and MEM both requesting reads.
    task automatic contend(input string tag);
        logic mem_wins;
`ifdef SPM_ARB_RR_EN
        mem_wins    = rr_mem_next;
        rr_mem_next = !rr_mem_next;
`else
        mem_wins = 1'b1;
`endif
        if (mem_wins) push(O_MEM, shadow[mem_spm_addr[7:0]]);
        else          push(O_IF,  shadow[if_spm_addr[7:0]]);
        @(negedge clk);
        chk({tag, "_addr"}, spm_addr, mem_wins ? mem_spm_addr : if_spm_addr);
        chk({tag, "_if_stall"}, if_stall, mem_wins);
        chk({tag, "_mem_stall"}, mem_stall, !mem_wins);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            spm_mem[i] = 32'hA500_0000 | i;
            shadow[i]  = 32'hA500_0000 | i;
        end
        spm_rd_data = '0;
        reset = 1'b1; cpu_en = 1'b0;
        test_spm_addr = '0; test_spm_rw = 1'b1; test_spm_wr_data = '0;
        if_spm_addr = '0; mem_spm_addr = '0; mem_spm_rw = 1'b1; mem_spm_wr_data = '0;
        idle_all();
        test_spm_as_ = 1'b0;
        if_spm_as_   = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst_spm_as", spm_as_, 1);
        chk("rst_err", test_spm_err, 0);
        chk("rst_if_stall", if_stall, 1);
        chk("rst_mem_stall", mem_stall, 0);
        tick();
        reset = 1'b0; idle_all();
        tick();

        // Loader write then reads in LOAD; a fetch is stalled meanwhile.
        test_spm_as_ = 1'b0; test_spm_rw = 1'b0; test_spm_addr = 0;
        test_spm_wr_data = 32'h0010_0093; shadow[0] = 32'h0010_0093;
        if_spm_as_ = 1'b0; if_spm_addr = 1;
        @(negedge clk);
        chk("load_wr_as", spm_as_, 0);
        chk("load_wr_rw", spm_rw, 0);
        chk("load_wr_data", spm_wr_data, 32'h0010_0093);
        chk("load_if_stall", if_stall, 1);
        chk("load_err", test_spm_err, 0);
        tick();
        if_spm_as_ = 1'b1; test_spm_rw = 1'b1;
        push(O_TEST, shadow[0]);
        @(negedge clk);
        chk("load_rd_rw", spm_rw, 1);
        chk("load_rd_addr", spm_addr, 0);
        tick();
        test_spm_addr = 5; push(O_TEST, shadow[5]);
        tick();

        // Handoff: cpu_en rises in a LOAD cycle that still grants the loader.
        test_spm_addr = 7; cpu_en = 1'b1; push(O_TEST, shadow[7]);
        @(negedge clk);
        chk("hand_n_as", spm_as_, 0);
        tick();
        if_spm_as_ = 1'b0; if_spm_addr = 1;
        @(negedge clk);
        chk("sw_as", spm_as_, 1);
        chk("sw_err", test_spm_err, 1);
        chk("sw_if_stall", if_stall, 1);
        tick();
        test_spm_as_ = 1'b1; push(O_IF, shadow[1]);
        @(negedge clk);
        chk("run_if_as", spm_as_, 0);
        chk("run_if_addr", spm_addr, 1);
        chk("run_if_stall", if_stall, 0);
        chk("run_err_idle", test_spm_err, 0);
        tick();
        test_spm_as_ = 1'b0; if_spm_as_ = 1'b1;
        @(negedge clk);
        chk("run_err", test_spm_err, 1);
        chk("run_ld_as", spm_as_, 1);
        tick();
        test_spm_as_ = 1'b1;

        // MEM store in RUN.
        mem_spm_as_ = 1'b0; mem_spm_rw = 1'b0; mem_spm_addr = 9;
        mem_spm_wr_data = 32'hDEAD_BEEF; shadow[9] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_rw", spm_rw, 0);
        chk("st_data", spm_wr_data, 32'hDEAD_BEEF);
        tick();

        // Contention IF@1 vs MEM read @4, then IF alone.
        if_spm_as_ = 1'b0; if_spm_addr = 1; mem_spm_rw = 1'b1; mem_spm_addr = 4;
        contend("cont1");
        mem_spm_as_ = 1'b1; push(O_IF, shadow[1]);
        @(negedge clk);
        chk("cont1_if_gnt", if_stall, 0);
        tick();

        // Four back-to-back contended cycles.
        mem_spm_as_ = 1'b0; if_spm_addr = 2; mem_spm_addr = 3;
        for (int k = 0; k < 4; k++) contend("cont4");
        mem_spm_as_ = 1'b1; if_spm_addr = 9; push(O_IF, shadow[9]);
        tick();

        // Drain: MEM read in the last RUN cycle returns during SWITCH.
        if_spm_as_ = 1'b1; mem_spm_as_ = 1'b0; mem_spm_addr = 4; cpu_en = 1'b0;
        push(O_MEM, shadow[4]);
        @(negedge clk);
        chk("drain_as", spm_as_, 0);
        tick();
        mem_spm_as_ = 1'b1; test_spm_as_ = 1'b0; test_spm_rw = 1'b1; test_spm_addr = 9;
        @(negedge clk);
        chk("drain_sw_err", test_spm_err, 1);
        chk("drain_sw_as", spm_as_, 1);
        tick();
        push(O_TEST, shadow[9]);
        @(negedge clk);
        chk("drain_ld_as", spm_as_, 0);
        chk("drain_ld_err", test_spm_err, 0);
        tick();

        // Reset with a MEM read in flight: the return must be dropped.
        idle_all(); cpu_en = 1'b1;
        tick(); tick();
        mem_spm_as_ = 1'b0; mem_spm_addr = 5;
        @(negedge clk);
        chk("rmr_gnt_as", spm_as_, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("rmr_as", spm_as_, 1);
        chk("rmr_mem_stall", mem_stall, 1);
        tick();
        reset = 1'b0; cpu_en = 1'b0; mem_spm_as_ = 1'b1;
        test_spm_as_ = 1'b0; test_spm_addr = 0; push(O_TEST, shadow[0]);
        @(negedge clk);
        chk("rmr_load_as", spm_as_, 0);
        tick();
        idle_all();
        tick(); tick(); tick();

        chk("sb_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
